// File: rtl/bias_serial_loader_if.sv
// Connection bundle between the regfile-side bias words and the serial bias loader.
// The loader takes the slave view; whoever supplies bias words and consumes status takes the master view.
interface bias_serial_loader_if #(
  parameter int NUM_BIASES = 4,
  parameter int BIAS_WIDTH = 24,
  parameter int CNT_WIDTH  = 8
);
  logic [NUM_BIASES-1:0][BIAS_WIDTH-1:0] bias_in;
  logic                                  commit;
  logic                                  auto_en;
  logic [NUM_BIASES-1:0][BIAS_WIDTH-1:0] bias_out;
  logic                                  sdo;
  logic                                  sck_out;
  logic                                  latch;
  logic                                  busy;
  logic                                  done;
  logic [CNT_WIDTH-1:0]                  commit_cnt;

  modport master (
    output bias_in, commit, auto_en,
    input  bias_out, sdo, sck_out, latch, busy, done, commit_cnt
  );

  modport slave (
    input  bias_in, commit, auto_en,
    output bias_out, sdo, sck_out, latch, busy, done, commit_cnt
  );
endinterface

// File: rtl/bias_serial_loader.sv
// Snapshots the bias words, shifts them MSB-first (last word first) into the analog bias chain,
// pulses the chain latch, then updates the held parallel copy in one step.
module bias_serial_loader #(
  parameter int NUM_BIASES = 4,
  parameter int BIAS_WIDTH = 24,
  parameter int CLK_DIV    = 2,
  parameter int CNT_WIDTH  = 8
) (
  input logic              clk,
  input logic              rst_n,
  bias_serial_loader_if.slave bus
);
  localparam int N     = NUM_BIASES * BIAS_WIDTH;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_LATCH,
    S_DONE
  } state_t;

  state_t           state;
  logic [N-1:0]     shadow;
  logic [N-1:0]     bias_in_flat;
  logic             pending;
  logic [DIV_W-1:0] div_cnt;
  logic [IDX_W-1:0] bit_idx;
  logic             start_req;

  // Word NUM_BIASES-1 lands in the top bits, so walking the flat vector downward gives the frame order.
  assign bias_in_flat = bus.bias_in;

  always_comb begin
    start_req = bus.commit || pending || (bus.auto_en && (bus.bias_in != bus.bias_out));
  end

  // NOTE: the shadow register is reset along with everything else, so an aborted load leaves no residue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      shadow         <= '0;
      pending        <= 1'b0;
      div_cnt        <= '0;
      bit_idx        <= '0;
      bus.bias_out   <= '0;
      bus.sdo        <= 1'b0;
      bus.sck_out    <= 1'b0;
      bus.latch      <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.commit_cnt <= '0;
    end else begin
      // NOTE: done is defaulted low every cycle so it can only ever be a one-cycle pulse.
      bus.done <= 1'b0;

      // Requests arriving mid-load collapse into a single deferred load.
      if (state != S_IDLE && bus.commit) begin
        pending <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (start_req) begin
            shadow      <= bias_in_flat;
            pending     <= 1'b0;
            div_cnt     <= '0;
            bit_idx     <= IDX_TOP;
            bus.sdo     <= bias_in_flat[N-1];
            bus.sck_out <= 1'b0;
            bus.busy    <= 1'b1;
            state       <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (!bus.sck_out) begin
              bus.sck_out <= 1'b1;
            end else begin
              // Falling edge closes a bit; sdo only moves while sck is low.
              bus.sck_out <= 1'b0;
              if (bit_idx == '0) begin
                bus.sdo   <= 1'b0;
                bus.latch <= 1'b1;
                state     <= S_LATCH;
              end else begin
                bit_idx <= bit_idx - IDX_W'(1);
                bus.sdo <= shadow[bit_idx - IDX_W'(1)];
              end
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        S_LATCH: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt        <= '0;
            bus.latch      <= 1'b0;
            bus.done       <= 1'b1;
            bus.bias_out   <= shadow;
            bus.commit_cnt <= bus.commit_cnt + CNT_WIDTH'(1);
            state          <= S_DONE;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        S_DONE: begin
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bias_serial_loader.sv
// Randomised bench for bias_serial_loader: a load-level reference model predicts each completed load,
// and a monitor reassembles the serial frame and compares it when done pulses.
module tb_bias_serial_loader;
  localparam int NB       = 4;
  localparam int BW       = 24;
  localparam int CD       = 2;
  localparam int CW       = 2;
  localparam int N        = NB * BW;
  localparam int LOAD_LEN = 2 * CD * N + CD + 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bias_serial_loader_if #(.NUM_BIASES(NB), .BIAS_WIDTH(BW), .CNT_WIDTH(CW)) bus ();

  bias_serial_loader #(
    .NUM_BIASES(NB),
    .BIAS_WIDTH(BW),
    .CLK_DIV   (CD),
    .CNT_WIDTH (CW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [N-1:0]  frame;
    logic [CW-1:0] cnt;
    int            done_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   done_seen = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic logic [N-1:0] rand_frame();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[N-1:0];
  endfunction

  // Reference model: a load is a fixed-length busy window; commits inside it set one pending flag.
  int           cyc = 0;
  int           m_busy = 0;
  logic         m_pending = 1'b0;
  logic [N-1:0] m_bias_out = '0;
  logic [N-1:0] m_shadow = '0;
  int           m_loads = 0;

  initial begin
    exp_t e;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_busy     = 0;
        m_pending  = 1'b0;
        m_bias_out = '0;
        m_loads    = 0;
        exp_q.delete();
      end else begin
        if (m_busy == 0) begin
          if (bus.commit || m_pending || (bus.auto_en && (bus.bias_in != m_bias_out))) begin
            m_shadow   = bus.bias_in;
            m_pending  = 1'b0;
            m_busy     = LOAD_LEN;
            e.frame    = bus.bias_in;
            e.cnt      = CW'(m_loads + 1);
            e.done_cyc = cyc + LOAD_LEN;
            exp_q.push_back(e);
          end
        end else begin
          if (bus.commit) m_pending = 1'b1;
          m_busy--;
          if (m_busy == 0) begin
            m_bias_out = m_shadow;
            m_loads++;
          end
        end
        cyc++;
      end
    end
  end

  // Monitor: samples on the falling clock edge, away from the DUT's update edge.
  logic         prev_sck = 1'b0;
  logic         prev_sdo = 1'b0;
  logic [N-1:0] rx = '0;
  int           rx_bits = 0;
  int           latch_cycles = 0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_sck     = 1'b0;
        prev_sdo     = 1'b0;
        rx_bits      = 0;
        latch_cycles = 0;
      end else begin
        check("busy", bus.busy, m_busy != 0);
        if (bus.sck_out && !prev_sck) begin
          rx = {rx[N-2:0], bus.sdo};
          rx_bits++;
        end
        if (bus.sck_out && prev_sck) check("sdo_stable_sck_high", bus.sdo, prev_sdo);
        if (bus.latch) begin
          latch_cycles++;
          check("latch_lines_low", {bus.sck_out, bus.sdo}, 2'b00);
        end
        if (bus.done) begin
          done_seen++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done: done pulsed at cycle %0d with no load predicted", cyc);
          end else begin
            e = exp_q.pop_front();
            check("frame",        rx,             e.frame);
            check("sck_edges",    rx_bits,        N);
            check("latch_len",    latch_cycles,   CD);
            check("done_cycle",   cyc,            e.done_cyc);
            check("bias_out",     bus.bias_out,   e.frame);
            check("commit_cnt",   bus.commit_cnt, e.cnt);
          end
          rx_bits      = 0;
          latch_cycles = 0;
        end
        prev_sck = bus.sck_out;
        prev_sdo = bus.sdo;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_commit();
    bus.commit = 1'b1;
    step(1);
    bus.commit = 1'b0;
  endtask

  task automatic wait_quiet(input string name);
    int n;
    n = 0;
    while (!(m_busy == 0 && !m_pending && exp_q.size() == 0 &&
             !(bus.auto_en && (bus.bias_in != m_bias_out))) && n < 5000) begin
      step(1);
      n++;
    end
    check({name, "_settle"}, n < 5000, 1'b1);
  endtask

  task automatic check_all_low(input string name);
    check({name, "_sdo"},        bus.sdo,        1'b0);
    check({name, "_sck"},        bus.sck_out,    1'b0);
    check({name, "_latch"},      bus.latch,      1'b0);
    check({name, "_busy"},       bus.busy,       1'b0);
    check({name, "_done"},       bus.done,       1'b0);
    check({name, "_commit_cnt"}, bus.commit_cnt, '0);
    check({name, "_bias_out"},   bus.bias_out,   '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int           d0;
    logic [N-1:0] t2_val;

    rst_n       = 1'b0;
    bus.commit  = 1'b0;
    bus.auto_en = 1'b0;
    bus.bias_in = '0;
    step(3);
    check_all_low("reset_state");
    rst_n = 1'b1;
    step(5);

    // Single load with a known pattern.
    t2_val      = {24'h000DDD, 24'h000CCC, 24'h000BBB, 24'h000AAA};
    bus.bias_in = t2_val;
    pulse_commit();
    wait_quiet("t2");
    check("t2_bias_out",   bus.bias_out,   t2_val);
    check("t2_commit_cnt", bus.commit_cnt, 1);

    // Reset asserted mid-shift, away from the clock edge.
    bus.bias_in = rand_frame();
    pulse_commit();
    step(100);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_low("t1_mid_load_reset");
    step(3);
    rst_n = 1'b1;
    step(20);
    check("t1_bias_out_after", bus.bias_out, '0);
    check("t1_busy_after",     bus.busy,     1'b0);

    // Three commits during one load merge into exactly one deferred load.
    d0          = done_seen;
    bus.bias_in = rand_frame();
    pulse_commit();
    step(50);
    for (int i = 0; i < 3; i++) begin
      pulse_commit();
      step($urandom_range(60, 10));
    end
    bus.bias_in = rand_frame();
    wait_quiet("t3");
    check("t3_load_count", done_seen - d0, 2);

    // bias_in moves halfway through the shift with auto mode off.
    bus.bias_in = rand_frame();
    pulse_commit();
    step(N * CD);
    bus.bias_in = rand_frame();
    wait_quiet("t5");

    // Auto mode: a single word change starts a load on its own, then nothing while steady.
    bus.bias_in = m_bias_out;
    bus.auto_en = 1'b1;
    step(5);
    check("t4_no_start_when_equal", bus.busy, 1'b0);
    bus.bias_in[2] = 24'h123456;
    step(1);
    check("t4_start_next_cycle", bus.busy, 1'b1);
    wait_quiet("t4");
    d0 = done_seen;
    step(1000);
    check("t4_steady_no_loads", done_seen - d0, 0);
    bus.auto_en = 1'b0;

    // Random mix of commits, auto changes and mid-load commits.
    for (int i = 0; i < 3; i++) begin
      bus.bias_in = rand_frame();
      if ($urandom_range(1, 0) == 1) begin
        pulse_commit();
      end else begin
        bus.auto_en = 1'b1;
        step(1);
      end
      step($urandom_range(400, 0));
      if ($urandom_range(1, 0) == 1) begin
        bus.bias_in = rand_frame();
        pulse_commit();
      end
      wait_quiet("rand");
      bus.auto_en = 1'b0;
    end

    step(10);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
